// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed display scan controller.
package display_scan_ctrl_pkg;

  localparam int CODE_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_e;

endpackage

// File: rtl/scan_slot_timer.sv
// Slot cycle counter: restarts at 0 whenever clr_i is high and flags the last
// cycle of the blanking interval and of the visible interval.
module scan_slot_timer #(
  parameter int SLOT_CYC  = 50000,
  parameter int BLANK_CYC = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic blank_tc_o,
  output logic show_tc_o
);

  localparam int CNT_W = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SLOT_CYC - BLANK_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = clr_i ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign blank_tc_o = (cnt_q == BLANK_LAST);
  assign show_tc_o  = (cnt_q == SHOW_LAST);

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed digit scanner with anti-ghost blanking and a tear-free
// double-buffered frame. Define DISPLAY_SCAN_LEADZERO_EN to suppress leading zeros.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SLOT_CYC   = 50000,
  parameter int BLANK_CYC  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         load_valid,
  input  logic [NUM_DIGITS*CODE_W-1:0] load_data,
  output logic                         load_ready,
  output logic [CODE_W-1:0]            code,
  output logic [NUM_DIGITS-1:0]        digit_en,
  output logic                         frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  typedef logic [NUM_DIGITS-1:0][CODE_W-1:0] frame_t;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  pending_q;
  frame_t                shadow_q, active_q;
  logic [CODE_W-1:0]     code_q;
  logic [NUM_DIGITS-1:0] digit_en_q;
  logic                  frame_done_q;

  logic blank_tc, show_tc, slot_clr, capture, xfer, dark;
  logic [NUM_DIGITS-1:0] onehot;

  scan_slot_timer #(
    .SLOT_CYC  (SLOT_CYC),
    .BLANK_CYC (BLANK_CYC)
  ) u_slot_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (slot_clr),
    .blank_tc_o (blank_tc),
    .show_tc_o  (show_tc)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        state_d = BLANK;
        idx_d   = '0;
      end
      BLANK: begin
        if (blank_tc) state_d = SHOW;
      end
      SHOW: begin
        if (show_tc) begin
          state_d = BLANK;
          idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
    if (!enable) begin
      state_d = IDLE;
      idx_d   = '0;
    end
  end

  // Every state is entered only through a change of state, so restarting the
  // counter on any change gives each state a fresh count from 0.
  assign slot_clr = (state_d != state_q) || (state_q == IDLE);
  assign capture  = load_valid && !pending_q;
  assign xfer     = pending_q &&
                    ((state_q == IDLE) ||
                     (state_q == SHOW && state_d == BLANK && idx_d == '0));
  assign onehot   = NUM_DIGITS'(1) << idx_q;

`ifdef DISPLAY_SCAN_LEADZERO_EN
  function automatic logic lead_zero(input frame_t f, input logic [IDX_W-1:0] i);
    logic z;
    z = (i != '0);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= int'(i) && f[k] != '0) z = 1'b0;
    end
    return z;
  endfunction

  assign dark = lead_zero(active_q, idx_q);
`else
  assign dark = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      shadow_q     <= '0;
      active_q     <= '0;
      code_q       <= '0;
      digit_en_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      // capture needs !pending and xfer needs pending, so they never collide
      if (capture) begin
        shadow_q  <= load_data;
        pending_q <= 1'b1;
      end else if (xfer) begin
        active_q  <= shadow_q;
        pending_q <= 1'b0;
      end
      code_q       <= (enable && state_q != IDLE) ? active_q[idx_q] : '0;
      digit_en_q   <= (enable && state_q == SHOW && !dark) ? onehot : '0;
      frame_done_q <= enable && (state_q == SHOW) && show_tc && (idx_q == LAST_IDX);
    end
  end

  assign load_ready = ~pending_q;
  assign code       = code_q;
  assign digit_en   = digit_en_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl (NUM_DIGITS=4, SLOT_CYC=10, BLANK_CYC=2).
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        load_valid;
  logic [19:0] load_data;
  logic        load_ready;
  logic [4:0]  code;
  logic [3:0]  digit_en;
  logic        frame_done;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  localparam logic [19:0] F1 = {5'h05, 5'h1F, 5'h02, 5'h13};
  localparam logic [19:0] F2 = {5'h0C, 5'h0B, 5'h0A, 5'h01};
  localparam logic [19:0] F3 = {5'h1A, 5'h19, 5'h18, 5'h17};
  localparam logic [19:0] F4 = {5'h00, 5'h00, 5'h07, 5'h00};
  localparam logic [19:0] FA = {5'h11, 5'h0A, 5'h09, 5'h1E};
`ifdef DISPLAY_SCAN_LEADZERO_EN
  localparam logic LZ = 1'b1;
`else
  localparam logic LZ = 1'b0;
`endif

  display_scan_ctrl #(
    .NUM_DIGITS (4),
    .SLOT_CYC   (10),
    .BLANK_CYC  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .code       (code),
    .digit_en   (digit_en),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] en, input logic [4:0] cd, input logic fd,
                      input logic rdy, input string tag);
    @(posedge clk);
    #1;
    chk({tag, ".digit_en"},   32'(digit_en),   32'(en));
    chk({tag, ".code"},       32'(code),       32'(cd));
    chk({tag, ".frame_done"}, 32'(frame_done), 32'(fd));
    chk({tag, ".load_ready"}, 32'(load_ready), 32'(rdy));
  endtask

  // One 10-cycle output window of digit idx: 2 dark cycles then 8 strobed.
  // act: 1 offer F2 then F3 back-to-back, 2 drop load_valid, 3 drop enable
  // and stop, 4 offer FA for one cycle, 5 stop.
  task automatic run_slot(input int idx, input logic [4:0] cd, input logic fd,
                          input logic drk, input logic [9:0] rmask,
                          input int act, input int act_t);
    logic [3:0] oh;
    oh = 4'(1 << idx);
    for (int t = 0; t < 10; t++) begin
      step((t < 2 || drk) ? 4'b0000 : oh, cd, (t == 9) ? fd : 1'b0, rmask[t],
           $sformatf("slot%0d.t%0d", idx, t));
      if (t == act_t) begin
        case (act)
          1: begin load_valid = 1'b1; load_data = F2; end
          2: load_valid = 1'b0;
          3: begin enable = 1'b0; return; end
          4: begin load_valid = 1'b1; load_data = FA; end
          5: return;
          default: ;
        endcase
      end
      if (t == act_t + 1) begin
        if (act == 1) load_data = F3;
        if (act == 4) load_valid = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; load_valid = 1'b0; load_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.digit_en",   32'(digit_en),   32'h0);
    chk("rst.code",       32'(code),       32'h0);
    chk("rst.frame_done", 32'(frame_done), 32'h0);
    chk("rst.load_ready", 32'(load_ready), 32'h1);

    // Load the first frame while idle; it goes straight to the active buffer.
    rst = 1'b0;
    load_valid = 1'b1; load_data = F1;
    chk("idle.ready_pre", 32'(load_ready), 32'h1);
    step(4'b0, 5'h0, 1'b0, 1'b0, "idle.capture");
    load_valid = 1'b0;
    step(4'b0, 5'h0, 1'b0, 1'b1, "idle.xfer");
    enable = 1'b1;
    step(4'b0, 5'h0, 1'b0, 1'b1, "start");

    // Frame 1; F2 offered mid idx=2 and F3 held back-to-back behind it.
    run_slot(0, 5'h13, 1'b0, 1'b0, 10'h3FF, 0, -1);
    run_slot(1, 5'h02, 1'b0, 1'b0, 10'h3FF, 0, -1);
    run_slot(2, 5'h1F, 1'b0, 1'b0, 10'b0000001111, 1, 3);
    run_slot(3, 5'h05, 1'b1, 1'b0, 10'b1000000000, 0, -1);

    // Frame 2 shown; F3 accepted on the first cycle after the transfer.
    run_slot(0, 5'h01, 1'b0, 1'b0, 10'h000, 2, 0);
    run_slot(1, 5'h0A, 1'b0, 1'b0, 10'h000, 0, -1);
    run_slot(2, 5'h0B, 1'b0, 1'b0, 10'h000, 0, -1);
    run_slot(3, 5'h0C, 1'b1, 1'b0, 10'b1000000000, 0, -1);

    // Frame 3, then enable dropped in the middle of idx=1 SHOW.
    run_slot(0, 5'h17, 1'b0, 1'b0, 10'h3FF, 0, -1);
    run_slot(1, 5'h18, 1'b0, 1'b0, 10'h3FF, 3, 5);
    step(4'b0, 5'h0, 1'b0, 1'b1, "disable.0");
    step(4'b0, 5'h0, 1'b0, 1'b1, "disable.1");

    // Leading-zero frame loaded while idle, then scan restarts at idx=0.
    load_valid = 1'b1; load_data = F4;
    step(4'b0, 5'h0, 1'b0, 1'b0, "lz.capture");
    load_valid = 1'b0;
    step(4'b0, 5'h0, 1'b0, 1'b1, "lz.xfer");
    enable = 1'b1;
    step(4'b0, 5'h0, 1'b0, 1'b1, "restart");
    run_slot(0, 5'h00, 1'b0, 1'b0, 10'h3FF, 0, -1);
    run_slot(1, 5'h07, 1'b0, 1'b0, 10'h3FF, 0, -1);
    run_slot(2, 5'h00, 1'b0, LZ,   10'h3FF, 0, -1);
    run_slot(3, 5'h00, 1'b1, LZ,   10'h3FF, 0, -1);

    // Leave a frame pending, then reset asynchronously mid-slot.
    run_slot(0, 5'h00, 1'b0, 1'b0, 10'b0000000111, 4, 2);
    run_slot(1, 5'h07, 1'b0, 1'b0, 10'h000, 5, 5);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.digit_en",   32'(digit_en),   32'h0);
    chk("arst.code",       32'(code),       32'h0);
    chk("arst.frame_done", 32'(frame_done), 32'h0);
    chk("arst.load_ready", 32'(load_ready), 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    enable = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
